mem_bus_arbiter: RTL

- Shares one unified single-port memory bus between the pipelined core's instruction-fetch port (I) and load/store port (D).
- Sits between the core's IF/MEM stages and the memory. Its per-port acks drive stall_pc / pipeline stall on miss-latency.
- One outstanding transaction. D has fixed priority; a starvation guard protects I. A watchdog aborts a hung bus.

---
 rtl/mem_bus_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port memory bus between the core's
// instruction-fetch port (I) and load/store port (D).
//  - One outstanding bus transaction at a time; D has fixed priority.
//  - A starvation guard lets a waiting I win after STARVE_LIMIT cycles.
//  - A watchdog aborts a transaction after TIMEOUT_CYCLES without m_ack.
//  - Optional performance counters are built when MEM_ARB_PERF_EN is defined.
//
// Handshake: a requester raises x_req with its fields and holds both steady
// until the single-cycle x_ack. The cycle after x_ack, a still-high x_req is
// a fresh request. On the bus, m_req stays high with stable m_* fields until
// the memory answers with a single-cycle m_ack (m_rdata valid with it); m_ack
// while m_req is low is ignored.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned STARVE_LIMIT   = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic              i_err,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_wstrb,
    output logic              d_ack,
    output logic              d_err,
    output logic [31:0]       d_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    input  logic              m_ack,
    input  logic [31:0]       m_rdata,
    output logic [1:0]        dbg_state
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_i_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_conflict_cycles
`endif
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;

    // The watchdog counter only has to reach TIMEOUT_CYCLES-1.
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST =
        TMO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [7:0]       wait_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             busy;
    logic             starve;
    logic             timeout;

    assign busy      = (state != IDLE);
    assign starve    = (STARVE_LIMIT != 0) && (32'(wait_cnt) >= STARVE_LIMIT);
    // m_ack in the last allowed cycle wins over the abort.
    assign timeout   = busy && !m_ack && (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);
    assign m_req     = busy;
    assign dbg_state = state;

    // Arbitration and completion: choose the next owner of the bus.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (d_req && !starve) begin
                    state_nxt = BUSY_D;
                end else if (i_req) begin
                    state_nxt = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (m_ack || timeout) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset abandons any transaction without an ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // I waiting counter: counts while I asks but does not own the bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 8'd0;
        end else if ((state_nxt == BUSY_I) && (state != BUSY_I)) begin
            wait_cnt <= 8'd0;
        end else if (!i_req) begin
            wait_cnt <= 8'd0;
        end else if ((state != BUSY_I) && (wait_cnt != 8'hFF)) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Watchdog: restarts from zero on every grant, counts unanswered cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (!busy) begin
            tmo_cnt <= '0;
        end else if (!m_ack) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    // Bus field mux: the owning port drives the bus, zeros otherwise.
    always_comb begin
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = 32'd0;
        m_wstrb = 4'd0;
        case (state)
            BUSY_I: begin
                m_addr = i_addr;
            end
            BUSY_D: begin
                m_we    = d_we;
                m_addr  = d_addr;
                m_wdata = d_wdata;
                m_wstrb = d_wstrb;
            end
            default: ;
        endcase
    end

    // Per-port completion: ack on m_ack or abort, data only on a real m_ack.
    always_comb begin
        i_ack   = (state == BUSY_I) && (m_ack || timeout);
        i_err   = (state == BUSY_I) && timeout;
        i_rdata = ((state == BUSY_I) && m_ack) ? m_rdata : 32'd0;
        d_ack   = (state == BUSY_D) && (m_ack || timeout);
        d_err   = (state == BUSY_D) && timeout;
        d_rdata = ((state == BUSY_D) && m_ack) ? m_rdata : 32'd0;
    end

`ifdef MEM_ARB_PERF_EN
    // Performance counters: grants per port and contended idle cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_i_grants        <= 32'd0;
            perf_d_grants        <= 32'd0;
            perf_conflict_cycles <= 32'd0;
        end else if (state == IDLE) begin
            if (state_nxt == BUSY_I) begin
                perf_i_grants <= perf_i_grants + 32'd1;
            end
            if (state_nxt == BUSY_D) begin
                perf_d_grants <= perf_d_grants + 32'd1;
            end
            if (i_req && d_req) begin
                perf_conflict_cycles <= perf_conflict_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
